// File: rtl/spi_peripheral.sv
`timescale 1ns/1ps
// spi_peripheral: oversampled SPI target. sclk/pico/cs are synchronised into
// the clock domain; bytes are received MSB-first onto rx_data/rx_valid and
// transmitted from a one-entry ready/valid holding register.
// Optional feature macro: SPI_PERIPHERAL_ECHO_EN (underrun byte = last rx_data,
// otherwise FILL_BYTE).
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | cs deasserted; counters/shifters held clear, poci off
// ST_SELECTED | cs asserted; sample/drive edges shift data in and out
module spi_peripheral #(
    parameter bit         CPOL      = 1'b0,
    parameter bit         CPHA      = 1'b0,
    parameter logic [7:0] FILL_BYTE = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       sclk,
    input  logic       pico,
    input  logic       cs,
    output logic       poci,
    output logic       poci_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic       busy
);

    typedef enum logic {
        ST_IDLE,
        ST_SELECTED
    } state_t;

    state_t state, state_next;

    // [0],[1] are the synchroniser stages, [2] is the history flop
    logic [2:0] sclk_sync;
    logic [2:0] pico_sync;
    logic [2:0] cs_sync;

    logic [2:0] bit_cnt;
    logic [7:0] rx_shift;
    logic [7:0] tx_shift;
    logic [7:0] hold;
    logic       hold_full;
    logic       rx_done;
    logic [7:0] underrun_byte;

    logic lead_edge, trail_edge, sample_edge, drive_edge, cs_fall;
    logic do_load, do_shift_tx, do_sample, do_clear;

`ifdef SPI_PERIPHERAL_ECHO_EN
    assign underrun_byte = rx_data;
`else
    assign underrun_byte = FILL_BYTE;
`endif

    assign lead_edge   = (sclk_sync[2] == CPOL) && (sclk_sync[1] != CPOL);
    assign trail_edge  = (sclk_sync[2] != CPOL) && (sclk_sync[1] == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign drive_edge  = CPHA ? lead_edge : trail_edge;
    assign cs_fall     = cs_sync[2] && !cs_sync[1];

    assign poci     = tx_shift[7];
    assign busy     = (state == ST_SELECTED);
    assign poci_oe  = busy;
    assign tx_ready = !hold_full;

    // Bring the asynchronous SPI pins into the clock domain
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= {3{CPOL}};
            pico_sync <= 3'b000;
            cs_sync   <= 3'b111;
        end else begin
            sclk_sync <= {sclk_sync[1:0], sclk};
            pico_sync <= {pico_sync[1:0], pico};
            cs_sync   <= {cs_sync[1:0], cs};
        end
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-cycle datapath strobes; deselect wins over any edge
    always_comb begin
        state_next  = state;
        do_load     = 1'b0;
        do_shift_tx = 1'b0;
        do_sample   = 1'b0;
        do_clear    = 1'b0;
        case (state)
            ST_IDLE: begin
                do_clear = 1'b1;
                if (cs_fall) begin
                    state_next = ST_SELECTED;
                    // CPHA=0 needs the MSB on poci before the first leading edge
                    do_load    = ~CPHA;
                end
            end
            ST_SELECTED: begin
                if (cs_sync[1]) begin
                    state_next = ST_IDLE;
                    do_clear   = 1'b1;
                end else if (sample_edge) begin
                    do_sample = 1'b1;
                end else if (drive_edge) begin
                    if (bit_cnt == 3'd0) begin
                        do_load = 1'b1;
                    end else begin
                        do_shift_tx = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Receive shifter, bit counter and rx_data/rx_valid
    always_ff @(posedge clock) begin
        if (reset) begin
            bit_cnt  <= 3'd0;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_done  <= 1'b0;
            rx_valid <= 1'b0;
        end else begin
            rx_done  <= 1'b0;
            rx_valid <= rx_done;
            if (do_clear) begin
                bit_cnt  <= 3'd0;
                rx_shift <= 8'h00;
            end else if (do_sample) begin
                rx_shift <= {rx_shift[6:0], pico_sync[2]};
                if (bit_cnt == 3'd7) begin
                    rx_data <= {rx_shift[6:0], pico_sync[2]};
                    rx_done <= 1'b1;
                    bit_cnt <= 3'd0;
                end else begin
                    bit_cnt <= bit_cnt + 3'd1;
                end
            end
        end
    end

    // Transmit shifter, holding register and underrun flag
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_shift    <= 8'h00;
            hold        <= 8'h00;
            hold_full   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            if (do_load) begin
                if (hold_full) begin
                    tx_shift <= hold;
                end else begin
                    tx_shift    <= underrun_byte;
                    tx_underrun <= 1'b1;
                end
            end else if (do_shift_tx) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
            end else if (do_clear) begin
                tx_shift <= 8'h00;
            end
            // a write only happens while empty, a load only drains while full
            if (tx_valid && !hold_full) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (do_load && hold_full) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_peripheral.sv
`timescale 1ns/1ps
// Bench for spi_peripheral: four instances (SPI modes 0..3) exercised one at a
// time by a behavioural SPI controller, with a byte-level reference model and
// a scoreboard monitor for rx bytes, poci bytes and underrun pulses.
module tb_spi_peripheral;

    localparam logic [3:0] CPOL_T = 4'b1100;
    localparam logic [3:0] CPHA_T = 4'b1010;
    localparam logic [7:0] FILL   = 8'h00;
    localparam int         GAP    = 8;

    logic       clock;
    logic       reset;
    logic       cs;
    logic       sclk_raw;
    logic       pico;
    logic [7:0] tx_data;
    logic       tx_valid;
    int         sel;
    int         half;

    logic       cs_v       [4];
    logic       sclk_v     [4];
    logic       tx_valid_v [4];
    logic       poci_w     [4];
    logic       poci_oe_w  [4];
    logic [7:0] rx_data_w  [4];
    logic       rx_valid_w [4];
    logic       tx_ready_w [4];
    logic       und_w      [4];
    logic       busy_w     [4];

    int checks;
    int errors;

    logic [7:0] exp_rx_q [$];
    logic [7:0] exp_tx_q [$];
    logic [7:0] m_hold   [$];
    logic [7:0] m_last_rx;
    int         m_und;
    int         und_seen;
    logic [7:0] ctl_buf [4];

    int         mon_bits;
    logic [7:0] mon_shift;
    logic       mon_prev;

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            assign cs_v[g]       = (sel == g) ? cs : 1'b1;
            assign sclk_v[g]     = (sel == g) ? (sclk_raw ^ CPOL_T[g]) : CPOL_T[g];
            assign tx_valid_v[g] = tx_valid && (sel == g);
            spi_peripheral #(
                .CPOL      (CPOL_T[g]),
                .CPHA      (CPHA_T[g]),
                .FILL_BYTE (FILL)
            ) u_dut (
                .clock       (clock),
                .reset       (reset),
                .sclk        (sclk_v[g]),
                .pico        (pico),
                .cs          (cs_v[g]),
                .poci        (poci_w[g]),
                .poci_oe     (poci_oe_w[g]),
                .rx_data     (rx_data_w[g]),
                .rx_valid    (rx_valid_w[g]),
                .tx_data     (tx_data),
                .tx_valid    (tx_valid_v[g]),
                .tx_ready    (tx_ready_w[g]),
                .tx_underrun (und_w[g]),
                .busy        (busy_w[g])
            );
        end
    endgenerate

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (mode %0d): got 0x%0h expected 0x%0h", name, sel, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Reference model: a load takes the held byte, else the underrun byte
    function automatic logic [7:0] model_load();
        logic [7:0] v;
        if (m_hold.size() != 0) begin
            v = m_hold.pop_front();
        end else begin
            m_und++;
`ifdef SPI_PERIPHERAL_ECHO_EN
            v = m_last_rx;
`else
            v = FILL;
`endif
        end
        return v;
    endfunction

    task automatic write_byte(input logic [7:0] b);
        int n;
        n = 0;
        while (!tx_ready_w[sel] && n < 64) begin
            cyc(1);
            n++;
        end
        check("tx_ready_wait", int'(tx_ready_w[sel]), 1);
        if (tx_ready_w[sel]) begin
            tx_data  = b;
            tx_valid = 1'b1;
            cyc(1);
            tx_valid = 1'b0;
            m_hold.push_back(b);
        end
    endtask

    task automatic bit_out(input bit cpha, input logic v);
        if (!cpha) begin
            pico = v;
            cyc(half);
            sclk_raw = 1'b1;
            cyc(half);
            sclk_raw = 1'b0;
        end else begin
            sclk_raw = 1'b1;
            pico = v;
            cyc(half);
            sclk_raw = 1'b0;
            cyc(half);
        end
    endtask

    task automatic check_reset_values();
        check("rst_poci", int'(poci_w[sel]), 0);
        check("rst_poci_oe", int'(poci_oe_w[sel]), 0);
        check("rst_rx_data", int'(rx_data_w[sel]), 0);
        check("rst_rx_valid", int'(rx_valid_w[sel]), 0);
        check("rst_tx_ready", int'(tx_ready_w[sel]), 1);
        check("rst_tx_underrun", int'(und_w[sel]), 0);
        check("rst_busy", int'(busy_w[sel]), 0);
    endtask

    task automatic reset_mid();
        reset    = 1'b1;
        cs       = 1'b1;
        sclk_raw = 1'b0;
        pico     = 1'b0;
        cyc(4);
        reset = 1'b0;
        cyc(3);
        m_hold.delete();
        m_last_rx = 8'h00;
        check_reset_values();
        check("rst_rx_pending", exp_rx_q.size(), 0);
    endtask

    // One cs-framed transfer; abort_bits/reset_bits cut byte 0 short
    task automatic xfer(input int nbytes, input int abort_bits, input int reset_bits,
                        input bit midwrite, input logic [7:0] mid_byte);
        logic [7:0] cur;
        logic [7:0] b;
        bit         cpha;
        bit         full;
        bit         stop;
        bit         did_reset;
        int         und_base;
        int         m_base;
        cpha      = CPHA_T[sel];
        full      = (abort_bits == 0) && (reset_bits == 0);
        stop      = 1'b0;
        did_reset = 1'b0;
        und_base  = und_seen;
        m_base    = m_und;
        cur       = 8'h00;
        cs        = 1'b0;
        if (!cpha) cur = model_load();
        cyc(GAP);
        check("busy_selected", int'(busy_w[sel]), 1);
        check("poci_oe_selected", int'(poci_oe_w[sel]), 1);
        for (int k = 0; k < nbytes && !stop; k++) begin
            b = ctl_buf[k];
            if (cpha) cur = model_load();
            if (full) begin
                exp_tx_q.push_back(cur);
                exp_rx_q.push_back(b);
            end
            for (int i = 0; i < 8 && !stop; i++) begin
                if (abort_bits != 0 && i == abort_bits) begin
                    stop = 1'b1;
                end else if (reset_bits != 0 && i == reset_bits) begin
                    reset_mid();
                    stop      = 1'b1;
                    did_reset = 1'b1;
                end else begin
                    bit_out(cpha, b[7-i]);
                    if (midwrite && k == 0 && i == 0 && m_hold.size() == 0)
                        write_byte(mid_byte);
                end
            end
            if (!stop) begin
                m_last_rx = b;
                // CPHA=0: the trailing edge after the 8th sample preloads
                if (!cpha) cur = model_load();
            end
        end
        if (!did_reset) begin
            cyc(GAP);
            cs = 1'b1;
            cyc(GAP + 4);
            check("tx_underrun_count", und_seen - und_base, m_und - m_base);
            check("tx_ready_after", int'(tx_ready_w[sel]), int'(m_hold.size() == 0));
            check("poci_oe_deselected", int'(poci_oe_w[sel]), 0);
            check("busy_deselected", int'(busy_w[sel]), 0);
            check("rx_pending", exp_rx_q.size(), 0);
            check("tx_pending", exp_tx_q.size(), 0);
        end
    endtask

    // Scoreboard monitor: rx bytes, underrun pulses, poci bytes at sample edges
    always @(negedge clock) begin
        if (rx_valid_w[sel] === 1'b1) begin
            if (exp_rx_q.size() == 0)
                check("rx_valid_unexpected", int'(rx_data_w[sel]), -1);
            else
                check("rx_data", int'(rx_data_w[sel]), int'(exp_rx_q.pop_front()));
        end
        if (und_w[sel] === 1'b1) und_seen++;
        if (cs) begin
            mon_bits = 0;
        end else if (sclk_raw != mon_prev && sclk_raw == (CPHA_T[sel] ? 1'b0 : 1'b1)) begin
            check("poci_oe_active", int'(poci_oe_w[sel]), 1);
            mon_shift = {mon_shift[6:0], poci_w[sel]};
            mon_bits++;
            if (mon_bits == 8) begin
                mon_bits = 0;
                if (exp_tx_q.size() == 0)
                    check("poci_byte_unexpected", int'(mon_shift), -1);
                else
                    check("poci_byte", int'(mon_shift), int'(exp_tx_q.pop_front()));
            end
        end
        mon_prev = sclk_raw;
    end

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        und_seen  = 0;
        m_und     = 0;
        m_last_rx = 8'h00;
        mon_bits  = 0;
        mon_shift = 8'h00;
        mon_prev  = 1'b0;
        reset     = 1'b1;
        cs        = 1'b1;
        sclk_raw  = 1'b0;
        pico      = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        sel       = 0;
        half      = 6;
        cyc(4);
        reset = 1'b0;
        cyc(2);
        for (int m = 0; m < 4; m++) begin
            sel = m;
            check_reset_values();
        end

        for (int m = 0; m < 4; m++) begin
            sel = m;
            half = 6;
            m_hold.delete();
            m_last_rx = 8'h00;

            write_byte(8'hA5);
            ctl_buf[0] = 8'h3C;
            xfer(1, 0, 0, 1'b0, 8'h00);

            write_byte(8'h11);
            ctl_buf[0] = 8'hF0;
            ctl_buf[1] = 8'h0F;
            xfer(2, 0, 0, 1'b1, 8'h22);

            ctl_buf[0] = 8'h5A;
            ctl_buf[1] = 8'hC3;
            xfer(2, 0, 0, 1'b0, 8'h00);

            ctl_buf[0] = 8'hB6;
            xfer(1, 4, 0, 1'b0, 8'h00);
            ctl_buf[0] = 8'h81;
            xfer(1, 0, 0, 1'b0, 8'h00);

            write_byte(8'h77);
            ctl_buf[0] = 8'hE7;
            xfer(1, 0, 5, 1'b1, 8'h99);
            ctl_buf[0] = 8'h42;
            xfer(1, 0, 0, 1'b0, 8'h00);

            repeat (6) begin
                n = int'($urandom_range(1, 3));
                for (int k = 0; k < 4; k++) ctl_buf[k] = 8'($urandom);
                half = int'($urandom_range(5, 8));
                if (m_hold.size() == 0 && $urandom_range(0, 1) == 1)
                    write_byte(8'($urandom));
                xfer(n, 0, 0, 1'($urandom_range(0, 1)), 8'($urandom));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
